// File: rtl/pal_pkg.sv
// Shared sizing, configuration-bit offsets and state type for the registered PAL fabric.
// Every plane offset is a function of (N, M, P), so the core and any tooling stay in step.
package pal_pkg;

   typedef enum logic {
      UNCONFIGURED = 1'b0,
      ACTIVE       = 1'b1
   } pal_state_e;

   function automatic int and_plane_bits(input int n, input int m, input int p);
      return p * 2 * (n + m);
   endfunction

   function automatic int or_plane_bits(input int m, input int p);
      return m * p;
   endfunction

   function automatic int mc_bits(input int m);
      return 2 * m;
   endfunction

   function automatic int chain_len(input int n, input int m, input int p);
      return and_plane_bits(n, m, p) + or_plane_bits(m, p) + mc_bits(m);
   endfunction

   localparam int DEFAULT_L = chain_len(8, 6, 11);

   // Literal k of term pi: k < n+m selects s[k], otherwise ~s[k-(n+m)].
   function automatic int and_idx(input int n, input int m, input int pi, input int k);
      return pi * 2 * (n + m) + k;
   endfunction

   function automatic int or_idx(input int n, input int m, input int p, input int mi, input int pi);
      return and_plane_bits(n, m, p) + mi * p + pi;
   endfunction

   function automatic int mc_reg_idx(input int n, input int m, input int p, input int mi);
      return and_plane_bits(n, m, p) + or_plane_bits(m, p) + 2 * mi;
   endfunction

   function automatic int mc_inv_idx(input int n, input int m, input int p, input int mi);
      return mc_reg_idx(n, m, p, mi) + 1;
   endfunction

endpackage

// File: rtl/pal_macrocell.sv
// One output macrocell: optional inversion, feedback register, and a
// combinational/registered output select gated by configuration validity.
module pal_macrocell (
   input  logic clk,
   input  logic res_n,
   input  logic c_i,
   input  logic inv_i,
   input  logic reg_en_i,
   input  logic cfg_valid_i,
   input  logic run_en_i,
   input  logic clr_i,
   output logic q_o,
   output logic out_o
);

   logic x;
   logic q_q;
   logic q_d;

   assign x = c_i ^ inv_i;

   // The register always tracks x when running, so feedback works even in combinational mode.
   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = 1'b0;
      end else if (run_en_i && cfg_valid_i) begin
         q_d = x;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o   = q_q;
   assign out_o = cfg_valid_i ? (reg_en_i ? q_q : x) : 1'b0;

endmodule

// File: rtl/pal_registered_core.sv
// Registered PAL core: serial configuration chain with length-checked commit into an
// active configuration that drives the AND/OR planes and M macrocells.
module pal_registered_core
   import pal_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 6,
   parameter int P = 11
) (
   input  logic         clk,
   input  logic         res_n,
   input  logic         cfg_in,
   input  logic         cfg_shift,
   input  logic         cfg_commit,
   output logic         cfg_out,
   output logic         cfg_valid,
   output logic         cfg_err,
   input  logic         run_en,
   input  logic [N-1:0] in_vars,
   output logic [M-1:0] out_vals
);

   localparam int NS = N + M;
   localparam int L  = chain_len(N, M, P);
   localparam int CW = $clog2(L + 2);

   logic [L-1:0]  chain_q,  chain_d;
   logic [L-1:0]  active_q, active_d;
   logic [CW-1:0] cnt_q,    cnt_d;
   logic          err_q,    err_d;
   pal_state_e    state_q,  state_d;
   logic          accept;

   logic [M-1:0]  mc_q;
   logic [NS-1:0] s;
   logic [P-1:0]  term;
   logic [M-1:0]  c;

   // A commit coinciding with a shift is refused so the applied image is never half-updated.
   always_comb begin
      chain_d  = chain_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      state_d  = state_q;
      accept   = cfg_commit && !cfg_shift && (cnt_q == CW'(L));
      if (cfg_shift) begin
         chain_d = {chain_q[L-2:0], cfg_in};
         if (cnt_q != CW'(L + 1)) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      if (cfg_commit) begin
         err_d = !accept;
         if (!cfg_shift) begin
            cnt_d = '0;
         end
         if (accept) begin
            active_d = chain_q;
            state_d  = ACTIVE;
         end
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         chain_q  <= '0;
         active_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         state_q  <= UNCONFIGURED;
      end else begin
         chain_q  <= chain_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         state_q  <= state_d;
      end
   end

   assign cfg_out   = chain_q[L-1];
   assign cfg_valid = (state_q == ACTIVE);
   assign cfg_err   = err_q;

   assign s = {mc_q, in_vars};

   genvar gi;
   generate
      for (gi = 0; gi < P; gi++) begin : g_term
         logic [2*NS-1:0] sel;
         assign sel = active_q[and_idx(N, M, gi, 0) +: 2*NS];
         // An empty term reads as 0 rather than the AND identity.
         assign term[gi] = (|sel) &
                           (&((~sel[NS-1:0] | s) & (~sel[2*NS-1:NS] | ~s)));
      end

      for (gi = 0; gi < M; gi++) begin : g_out
         assign c[gi] = |(active_q[or_idx(N, M, P, gi, 0) +: P] & term);

         pal_macrocell u_mc (
            .clk         (clk),
            .res_n       (res_n),
            .c_i         (c[gi]),
            .inv_i       (active_q[mc_inv_idx(N, M, P, gi)]),
            .reg_en_i    (active_q[mc_reg_idx(N, M, P, gi)]),
            .cfg_valid_i (cfg_valid),
            .run_en_i    (run_en),
            .clr_i       (accept),
            .q_o         (mc_q[gi]),
            .out_o       (out_vals[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pal_registered_core.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_pal_registered_core;

   localparam int BL = 386;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       res_n, cfg_in, cfg_shift, cfg_commit, run_en;
   logic [1:0] in_vars;
   logic       cfg_out, cfg_valid, cfg_err;
   logic [1:0] out_vals;

   logic       b_in, b_shift, b_commit, b_run;
   logic [7:0] b_vars;
   logic       b_out, b_valid, b_err;
   logic [5:0] b_vals;

   pal_registered_core #(.N(2), .M(2), .P(2)) u_dut (
      .clk(clk), .res_n(res_n), .cfg_in(cfg_in), .cfg_shift(cfg_shift),
      .cfg_commit(cfg_commit), .cfg_out(cfg_out), .cfg_valid(cfg_valid),
      .cfg_err(cfg_err), .run_en(run_en), .in_vars(in_vars), .out_vals(out_vals)
   );

   pal_registered_core u_big (
      .clk(clk), .res_n(res_n), .cfg_in(b_in), .cfg_shift(b_shift),
      .cfg_commit(b_commit), .cfg_out(b_out), .cfg_valid(b_valid),
      .cfg_err(b_err), .run_en(b_run), .in_vars(b_vars), .out_vals(b_vals)
   );

   typedef struct packed {
      logic [79:0] name;
      logic        big;
      logic [5:0]  out;
      logic        valid;
      logic        err;
      logic        chk_co;
      logic        co;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   exp_t mon_e;
   logic [5:0] act_out;
   logic act_valid, act_err, ok;

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         mon_e     = sb.pop_front();
         act_out   = mon_e.big ? b_vals  : {4'b0, out_vals};
         act_valid = mon_e.big ? b_valid : cfg_valid;
         act_err   = mon_e.big ? b_err   : cfg_err;
         ok = (act_out == mon_e.out) && (act_valid == mon_e.valid) &&
              (act_err == mon_e.err) && (!mon_e.chk_co || (cfg_out == mon_e.co));
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL %0s: got out=%b valid=%b err=%b cfg_out=%b, want out=%b valid=%b err=%b cfg_out=%b",
                     mon_e.name, act_out, act_valid, act_err, cfg_out,
                     mon_e.out, mon_e.valid, mon_e.err, mon_e.chk_co ? mon_e.co : cfg_out);
         end else begin
            $display("ok   %0s: out=%b valid=%b err=%b cfg_out=%b",
                     mon_e.name, act_out, act_valid, act_err, cfg_out);
         end
      end
   end

   task automatic push(input logic [79:0] nm, input logic big, input logic [5:0] o,
                       input logic v, input logic e, input logic chk, input logic co);
      exp_t x;
      x.name = nm; x.big = big; x.out = o; x.valid = v; x.err = e; x.chk_co = chk; x.co = co;
      sb.push_back(x);
      @(negedge clk);
      #1;
   endtask

   task automatic expect_s(input logic [79:0] nm, input logic [1:0] o, input logic v, input logic e);
      push(nm, 1'b0, {4'b0, o}, v, e, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_small(input logic [23:0] cfg, input int nbits);
      for (int i = 23; i > 23 - nbits; i--) begin
         cfg_shift = 1'b1;
         cfg_in    = cfg[i];
         step();
      end
      cfg_shift = 1'b0;
   endtask

   task automatic commit_small();
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
   endtask

   // term0 = in0 & ~in1 -> out0 combinational
   localparam logic [23:0] CFG_A = 24'h010021;
   // adds term1 = ~q1 -> out1 registered
   localparam logic [23:0] CFG_B = 24'h498021;
   localparam logic [23:0] STREAM = 24'hA5C396;

   logic [BL-1:0] big_cfg;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      res_n = 1'b0; cfg_in = 1'b0; cfg_shift = 1'b0; cfg_commit = 1'b0; run_en = 1'b0;
      in_vars = 2'b01;
      b_in = 1'b0; b_shift = 1'b0; b_commit = 1'b0; b_run = 1'b0; b_vars = 8'h00;
      big_cfg = '0;
      for (int m = 0; m < 6; m++) big_cfg[375 + 2*m] = 1'b1;

      // reset state
      step();
      push("rst_01", 1'b0, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      in_vars = 2'b11;
      expect_s("rst_11", 2'b00, 1'b0, 1'b0);
      res_n = 1'b1;
      in_vars = 2'b10;
      step();
      expect_s("post_rst", 2'b00, 1'b0, 1'b0);

      // first configuration: out0 = in0 & ~in1 combinational
      load_small(CFG_A, 24);
      expect_s("pre_cmt", 2'b00, 1'b0, 1'b0);
      commit_small();
      in_vars = 2'b01;
      expect_s("comb_01", 2'b01, 1'b1, 1'b0);
      in_vars = 2'b11;
      expect_s("comb_11", 2'b00, 1'b1, 1'b0);
      in_vars = 2'b00;
      expect_s("comb_00", 2'b00, 1'b1, 1'b0);

      // short load is rejected, prior config still in use
      load_small(24'hFFFFFF, 23);
      commit_small();
      in_vars = 2'b01;
      expect_s("short_cmt", 2'b01, 1'b1, 1'b1);
      load_small(CFG_A, 24);
      commit_small();
      expect_s("reload", 2'b01, 1'b1, 1'b0);

      // registered toggle on out1 via ~q1 feedback
      in_vars = 2'b00;
      load_small(CFG_B, 24);
      commit_small();
      expect_s("tog_0", 2'b00, 1'b1, 1'b0);
      run_en = 1'b1;
      step();
      expect_s("tog_1", 2'b10, 1'b1, 1'b0);
      step();
      expect_s("tog_2", 2'b00, 1'b1, 1'b0);
      step();
      expect_s("tog_3", 2'b10, 1'b1, 1'b0);
      run_en = 1'b0;
      step();
      expect_s("hold_1", 2'b10, 1'b1, 1'b0);
      step();
      expect_s("hold_2", 2'b10, 1'b1, 1'b0);

      // readback: second stream pushes the first one out in original order
      load_small(STREAM, 24);
      for (int i = 0; i < 24; i++) begin
         push("readback", 1'b0, 6'b000010, 1'b1, 1'b0, 1'b1, STREAM[23 - i]);
         cfg_shift = 1'b1;
         cfg_in    = 1'b1;
         step();
      end
      cfg_shift = 1'b0;

      // reset in the middle of a load
      load_small(CFG_A, 10);
      res_n = 1'b0;
      push("rst_mid", 1'b0, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      res_n = 1'b1;
      step();
      in_vars = 2'b01;
      commit_small();
      expect_s("cmt_after_rst", 2'b00, 1'b0, 1'b1);

      // shift and commit in the same cycle at count 23
      load_small(CFG_A, 24);
      commit_small();
      expect_s("cfg_again", 2'b01, 1'b1, 1'b0);
      load_small(CFG_A, 23);
      cfg_shift  = 1'b1;
      cfg_in     = CFG_A[0];
      cfg_commit = 1'b1;
      step();
      cfg_shift  = 1'b0;
      cfg_commit = 1'b0;
      expect_s("shift_cmt", 2'b01, 1'b1, 1'b1);

      // default-size fabric: every macrocell inverts an empty OR -> all ones
      push("big_pre", 1'b1, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = BL - 1; i >= 0; i--) begin
         b_shift = 1'b1;
         b_in    = big_cfg[i];
         step();
      end
      b_shift  = 1'b0;
      b_commit = 1'b1;
      step();
      b_commit = 1'b0;
      push("big_cmt", 1'b1, 6'b111111, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d, want 0", sb.size());
      end
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
